// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register-index width, stage-index constants, forward-select
// encoding, scoreboard entry layout and the load-use predicate.
package pipe_pkg;

  localparam int REG_AW  = 5;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;  // last tracked stage for the default 3-deep pipe
  localparam int FWD_RF  = 0;  // forward select value meaning "read the regfile"

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic              v;   // stage holds a real instruction
    logic              we;  // writes a non-zero rd
    logic [REG_AW-1:0] rd;
    logic              ld;  // result comes from memory
  } sb_entry_t;

  // A load is not forwardable while it sits at or before stage load_lat.
  function automatic logic is_load_use(input logic hit, input logic ld,
                                       input int sel, input int load_lat);
    return hit && ld && (sel <= load_lat);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request/response bundle between the decode stage and the hazard controller.
// Latency: responses are combinational from request plus controller state.
// Backpressure: stall asks ID to hold its instruction; flush kills it.
// Ports (master = decode side, slave = controller):
//   id_*           decode-stage instruction fields, ex_redirect from stage 1
//   fwd1/2_sel     operand source per rs, stall/flush, stage_valid, event counters
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 32
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic              id_rs1_used;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rf_we;
  logic              id_is_load;
  logic              ex_redirect;

  logic [SEL_W-1:0]  fwd1_sel;
  logic [SEL_W-1:0]  fwd2_sel;
  logic              stall;
  logic              flush;
  logic [DEPTH-1:0]  stage_valid;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_rf_we, id_is_load, ex_redirect,
    input  fwd1_sel, fwd2_sel, stall, flush, stage_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
           id_rd, id_rf_we, id_is_load, ex_redirect,
    output fwd1_sel, fwd2_sel, stall, flush, stage_valid, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_src_match.sv
// Priority match of one source register against all tracked pipeline stages.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rs/used source request, sb scoreboard (index 1 = youngest),
//        hit/sel/is_load_hit describing the youngest matching producer.
module hazard_src_match #(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic [pipe_pkg::REG_AW-1:0]    rs,
  input  logic                           used,
  input  pipe_pkg::sb_entry_t [DEPTH:1]  sb,
  output logic                           hit,
  output logic [SEL_W-1:0]               sel,
  output logic                           is_load_hit
);
  import pipe_pkg::*;

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    hit         = 1'b0;
    sel         = SEL_W'(FWD_RF);
    is_load_hit = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (used && (rs != '0) && sb[k].v && sb[k].we && (sb[k].rd == rs)) begin
        hit         = 1'b1;
        sel         = SEL_W'(k);
        is_load_hit = sb[k].ld;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: scoreboard of in-flight rd, forward selects, load-use stall, redirect flush.
// Latency: fwd/stall/flush combinational from scoreboard and ID inputs; stage_valid and counters registered.
// Backpressure: stall holds PC and IF/ID and inserts a bubble; flush overrides stall.
// Ports: clk, rst_n (async, active low), bus (pipe_hazard_ctrl_if.slave) carrying
//        ID request fields, ex_redirect, fwd1/2_sel, stall, flush, stage_valid, stall_cnt, flush_cnt.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = pipe_pkg::REG_AW,
  parameter int DEPTH    = pipe_pkg::STG_WB,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_hazard_ctrl_if.slave  bus
);
  import pipe_pkg::*;

  localparam int SEL_W = $clog2(DEPTH + 1);
  localparam int RD_W  = pipe_pkg::REG_AW;

  sb_entry_t [DEPTH:1] sb;
  sb_entry_t           sb_in;

  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              hit1, hit2, ld1, ld2;
  logic [SEL_W-1:0]  sel1, sel2;
  logic              hazard, stall, flush;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;
  logic [DEPTH-1:0]  stage_valid;

  assign id_rs1 = bus.id_rs1;
  assign id_rs2 = bus.id_rs2;
  assign id_rd  = bus.id_rd;

  hazard_src_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_rs1_match (
    .rs          (RD_W'(id_rs1)),
    .used        (bus.id_rs1_used),
    .sb          (sb),
    .hit         (hit1),
    .sel         (sel1),
    .is_load_hit (ld1)
  );

  hazard_src_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_rs2_match (
    .rs          (RD_W'(id_rs2)),
    .used        (bus.id_rs2_used),
    .sb          (sb),
    .hit         (hit2),
    .sel         (sel2),
    .is_load_hit (ld2)
  );

  assign hazard = is_load_use(hit1, ld1, int'(sel1), LOAD_LAT) ||
                  is_load_use(hit2, ld2, int'(sel2), LOAD_LAT);

  // A redirect discards the ID instruction anyway, so it never also stalls.
  assign flush = bus.ex_redirect;
  assign stall = bus.id_valid && hazard && !flush;

  // Entry entering stage 1; x0 writes are tracked as non-writing.
  always_comb begin
    sb_in = '0;
    if (bus.id_valid && !stall && !flush) begin
      sb_in.v  = 1'b1;
      sb_in.we = bus.id_rf_we && (id_rd != '0);
      sb_in.rd = RD_W'(id_rd);
      sb_in.ld = bus.id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb[STG_EX] <= sb_in;
      for (int k = STG_MEM; k <= DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    stage_valid = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      stage_valid[k-1] = sb[k].v;
    end
  end

  assign bus.fwd1_sel    = sel1;
  assign bus.fwd2_sel    = sel2;
  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.stage_valid = stage_valid;
  assign bus.stall_cnt   = stall_cnt;
  assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random ID traffic against an issue-log model.
// Two instances share stimulus; the second has 4-bit counters to exercise saturation.
// Expected values come from a per-cycle log of what was issued into stage 1.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 1;
  localparam int SMALL_W  = 4;
  localparam int SMALL_MX = 15;
  localparam int LOGN     = 4096;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(DEPTH), .CNT_W(32))      ifa ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .DEPTH(DEPTH), .CNT_W(SMALL_W)) ifb ();

  assign ifb.id_valid    = ifa.id_valid;
  assign ifb.id_rs1      = ifa.id_rs1;
  assign ifb.id_rs1_used = ifa.id_rs1_used;
  assign ifb.id_rs2      = ifa.id_rs2;
  assign ifb.id_rs2_used = ifa.id_rs2_used;
  assign ifb.id_rd       = ifa.id_rd;
  assign ifb.id_rf_we    = ifa.id_rf_we;
  assign ifb.id_is_load  = ifa.id_is_load;
  assign ifb.ex_redirect = ifa.ex_redirect;

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(SMALL_W)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  // Issue log: entry e describes what entered stage 1 at clock edge e.
  bit         lg_iss [LOGN];
  logic [4:0] lg_rd  [LOGN];
  bit         lg_we  [LOGN];
  bit         lg_ld  [LOGN];
  int n        = 0;  // clock edges seen
  int rst_mark = 0;  // log entries at or before this index predate the last reset
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
  int checks   = 0;
  int failures = 0;

  int         e_sel1, e_sel2;
  bit         e_stall, e_flush;
  logic [2:0] e_sv;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Youngest earlier instruction still in flight that writes rs.
  task automatic find(input logic [4:0] rs, input bit used, output int sel, output bit ld);
    sel = 0;
    ld  = 1'b0;
    if (used && rs != 5'd0) begin
      for (int k = 1; k <= DEPTH; k++) begin
        int idx;
        idx = n - k + 1;
        if (sel == 0 && idx > rst_mark && lg_iss[idx] && lg_we[idx] && lg_rd[idx] == rs) begin
          sel = k;
          ld  = lg_ld[idx];
        end
      end
    end
  endtask

  task automatic eval();
    bit l1, l2;
    bit lu1, lu2;
    find(ifa.id_rs1, ifa.id_rs1_used, e_sel1, l1);
    find(ifa.id_rs2, ifa.id_rs2_used, e_sel2, l2);
    lu1 = l1 && e_sel1 > 0 && e_sel1 <= LOAD_LAT;
    lu2 = l2 && e_sel2 > 0 && e_sel2 <= LOAD_LAT;
    e_flush = ifa.ex_redirect;
    e_stall = ifa.id_valid && !ifa.ex_redirect && (lu1 || lu2);
    for (int k = 1; k <= DEPTH; k++) begin
      e_sv[k-1] = (n - k + 1 > rst_mark) && lg_iss[n - k + 1];
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2, input logic [4:0] rd,
                       input bit we, input bit ld, input bit redir);
    ifa.id_valid    = v;
    ifa.id_rs1      = rs1;
    ifa.id_rs1_used = u1;
    ifa.id_rs2      = rs2;
    ifa.id_rs2_used = u2;
    ifa.id_rd       = rd;
    ifa.id_rf_we    = we;
    ifa.id_is_load  = ld;
    ifa.ex_redirect = redir;
  endtask

  // Sample on the falling edge and compare every output against the model.
  task automatic step();
    @(negedge clk);
    eval();
    check("fwd1_sel", ifa.fwd1_sel, e_sel1);
    check("fwd2_sel", ifa.fwd2_sel, e_sel2);
    check("stall", ifa.stall, e_stall);
    check("flush", ifa.flush, e_flush);
    check("stage_valid", ifa.stage_valid, e_sv);
    check("stall_cnt", ifa.stall_cnt, m_stall_cnt);
    check("flush_cnt", ifa.flush_cnt, m_flush_cnt);
    check("sat_stall", ifb.stall, e_stall);
    check("sat_stall_cnt", ifb.stall_cnt, (m_stall_cnt > SMALL_MX) ? SMALL_MX : m_stall_cnt);
    check("sat_flush_cnt", ifb.flush_cnt, (m_flush_cnt > SMALL_MX) ? SMALL_MX : m_flush_cnt);
  endtask

  // Advance one clock and record what entered stage 1.
  task automatic adv();
    @(posedge clk);
    if (!rst_n) begin
      n++;
      rst_mark    = n;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      eval();
      n++;
      lg_iss[n] = ifa.id_valid && !e_stall && !e_flush;
      lg_rd[n]  = ifa.id_rd;
      lg_we[n]  = ifa.id_rf_we;
      lg_ld[n]  = ifa.id_is_load;
      if (e_stall) m_stall_cnt++;
      if (e_flush) m_flush_cnt++;
    end
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    nop();
    #2;
    check("rst_stall", ifa.stall, 0);
    check("rst_stage_valid", ifa.stage_valid, 0);
    check("rst_stall_cnt", ifa.stall_cnt, 0);
    check("rst_fwd1", ifa.fwd1_sel, 0);
    ifa.ex_redirect = 1'b1;
    #1;
    check("rst_flush_follows_redirect", ifa.flush, 1);
    ifa.ex_redirect = 1'b0;
    adv();
    @(negedge clk);
    rst_n = 1'b1;
    adv();

    // ALU dependency: forward from stage 1, then stage 2.
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0); step(); adv();
    drive(1, 5, 1, 5, 1, 6, 1, 0, 0); step();
    check("t1_fwd1_s1", ifa.fwd1_sel, 1);
    check("t1_fwd2_s1", ifa.fwd2_sel, 1);
    check("t1_no_stall", ifa.stall, 0);
    adv();
    drive(1, 5, 1, 5, 1, 0, 0, 0, 0); step();
    check("t1_fwd1_s2", ifa.fwd1_sel, 2);
    adv();

    // Redirect beats a pending load-use.
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0); step(); adv();
    drive(1, 6, 1, 0, 0, 7, 1, 0, 1); step();
    check("t3_flush", ifa.flush, 1);
    check("t3_stall", ifa.stall, 0);
    adv();
    nop(); step();
    check("t3_sv0", ifa.stage_valid[0], 0);
    check("t3_flush_cnt", ifa.flush_cnt, 1);
    adv();

    // Load-use: one stall cycle, then forward from stage 2.
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0); step(); adv();
    drive(1, 6, 1, 0, 0, 7, 1, 0, 0); step();
    check("t2_stall", ifa.stall, 1);
    adv();
    step();
    check("t2_released", ifa.stall, 0);
    check("t2_fwd1", ifa.fwd1_sel, 2);
    check("t2_bubble", ifa.stage_valid[0], 0);
    check("t2_stall_cnt", ifa.stall_cnt, 1);
    adv();

    // x0 is never a producer.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0); step(); adv();
    drive(1, 0, 1, 0, 1, 8, 1, 0, 0); step();
    check("t4_fwd1", ifa.fwd1_sel, 0);
    check("t4_fwd2", ifa.fwd2_sel, 0);
    check("t4_stall", ifa.stall, 0);
    check("t4_sv0", ifa.stage_valid[0], 1);
    adv();

    // Youngest producer wins; oldest used when alone.
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); step(); adv();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step(); adv();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); step(); adv();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0); step();
    check("t5_youngest", ifa.fwd1_sel, 1);
    adv();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0); step(); adv();
    nop(); step(); adv();
    nop(); step(); adv();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0); step();
    check("t5_wb", ifa.fwd1_sel, 3);
    adv();

    // Random traffic over a small register set to provoke many matches.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8,
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      step();
      adv();
    end

    // Asynchronous reset in the middle of a stall.
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0); step(); adv();
    drive(1, 6, 1, 0, 0, 7, 1, 0, 0); step();
    check("t6_pre_stall", ifa.stall, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_stall", ifa.stall, 0);
    check("t6_rst_sv", ifa.stage_valid, 0);
    check("t6_rst_stall_cnt", ifa.stall_cnt, 0);
    check("t6_rst_flush_cnt", ifa.flush_cnt, 0);
    check("t6_rst_fwd1", ifa.fwd1_sel, 0);
    check("t6_rst_sat_cnt", ifb.stall_cnt, 0);
    rst_mark    = n;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    #1;
    rst_n = 1'b1;
    adv();

    // Twenty load-use stalls: 4-bit counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 0, 0, 0, 6, 1, 1, 0); step(); adv();
      drive(1, 6, 1, 0, 0, 7, 1, 0, 0); step();
      check("t6_loop_stall", ifa.stall, 1);
      adv();
      step(); adv();
    end
    nop(); step();
    check("t6_stall_cnt_20", ifa.stall_cnt, 20);
    check("t6_sat_cnt_15", ifb.stall_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
